// File: rtl/regfile_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_stream_reader
// Purpose  : Reads a burst of register-file words and streams them out on a
//            valid/ready interface with a last-beat marker.
// Options  : `define REGFILE_READER_STRIDE_EN adds a per-command stride input.
// Revision : 1.0
// ============================================================================
module regfile_stream_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_DEPTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_base,
    input  logic [ADDRESS_WIDTH:0]   cmd_len,
`ifdef REGFILE_READER_STRIDE_EN
    input  logic [ADDRESS_WIDTH-1:0] cmd_stride,
`endif
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDRESS_WIDTH:0] c_depth = (ADDRESS_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] c_one   = (ADDRESS_WIDTH+1)'(1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nx;
    logic [ADDRESS_WIDTH-1:0] r_ptr;
    logic [ADDRESS_WIDTH:0]   r_remaining;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic                     r_done;

    logic                     w_accept;
    logic                     w_load;
    logic                     w_finish;
    logic [ADDRESS_WIDTH-1:0] w_base;
    logic [ADDRESS_WIDTH:0]   w_len;
    logic [ADDRESS_WIDTH:0]   w_stride;
    logic [ADDRESS_WIDTH:0]   w_sum;
    logic [ADDRESS_WIDTH-1:0] w_ptr_nx;

    // Out-of-range bases restart at word 0; lengths saturate at the file size.
    assign w_base = ({1'b0, cmd_base} >= c_depth) ? '0 : cmd_base;
    assign w_len  = (cmd_len > c_depth) ? c_depth : cmd_len;

`ifdef REGFILE_READER_STRIDE_EN
    logic [ADDRESS_WIDTH:0] r_stride;
    logic [ADDRESS_WIDTH:0] w_stride_in;

    assign w_stride_in = {1'b0, cmd_stride} % c_depth;
    assign w_stride    = r_stride;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stride <= '0;
        end else if (w_accept) begin
            r_stride <= w_stride_in;
        end
    end
`else
    assign w_stride = c_one;
`endif

    // Both operands are below DATA_DEPTH, so one conditional subtract wraps.
    assign w_sum    = {1'b0, r_ptr} + w_stride;
    assign w_ptr_nx = (w_sum >= c_depth) ? ADDRESS_WIDTH'(w_sum - c_depth)
                                         : ADDRESS_WIDTH'(w_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_load     = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = cmd_valid;
                if (cmd_valid && (w_len != '0)) begin
                    w_state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                w_load   = (r_remaining != '0) && (!r_out_valid || out_ready);
                w_finish = r_out_valid && out_ready && r_out_last;
                if (w_finish) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish || (w_accept && (w_len == '0));
            if (w_accept) begin
                r_ptr       <= w_base;
                r_remaining <= w_len;
            end
            if (w_load) begin
                r_out_data  <= rd_data;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_remaining == c_one);
                r_ptr       <= w_ptr_nx;
                r_remaining <= r_remaining - c_one;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_STREAM);
    assign rd_addr   = r_ptr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign done      = r_done;

endmodule
`default_nettype wire
